// File: rtl/sigmoid_layer_sequencer_if.sv
// sigmoid_layer_sequencer_if: sigmoid input, register-file and hidden-stream signals of the layer sequencer.
interface sigmoid_layer_sequencer_if #(parameter int NUM_OUT = 10);
    logic                        sig_valid;
    logic [3:0]                  sig_data;
    logic                        reg_write_en;
    logic [4:0]                  reg_address;
    logic [3:0]                  reg_data_in;
    logic [3:0]                  reg_data_out;
    logic [0:NUM_OUT-1][3:0]     digit_weights;
    logic [3:0]                  hidden_data;
    logic                        hidden_valid;
    logic                        hidden_ready;
    modport master (
        input  sig_valid, sig_data, reg_data_out, digit_weights, hidden_ready,
        output reg_write_en, reg_address, reg_data_in, hidden_data, hidden_valid
    );
    modport slave (
        output sig_valid, sig_data, reg_data_out, digit_weights, hidden_ready,
        input  reg_write_en, reg_address, reg_data_in, hidden_data, hidden_valid
    );
endinterface

// File: rtl/sigmoid_layer_sequencer.sv
// sigmoid_layer_sequencer: drives one classification through hidden capture, output replay/capture and argmax.
module sigmoid_layer_sequencer #(
    parameter int NUM_HIDDEN = 8,
    parameter int NUM_OUT    = 10
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start_i,
    sigmoid_layer_sequencer_if.master bus,
    output logic                      layer_sel_o,
    output logic [3:0]                out_neuron_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [3:0]                digit_o
);
    localparam int HW = $clog2(NUM_HIDDEN);
    localparam int OW = $clog2(NUM_OUT);
    typedef enum logic [2:0] {IDLE, HID, FEED, OWAIT, ARGMAX, DONE} state_t;
    state_t          state_q, state_d;
    logic [HW-1:0]   hid_cnt_q, hid_cnt_d, feed_cnt_q, feed_cnt_d;
    logic [OW-1:0]   out_cnt_q, out_cnt_d, idx_q, idx_d, best_idx_q, best_idx_d;
    logic [3:0]      best_q, best_d, digit_q, digit_d;
    logic [3:0]      w;
    logic            gt;
    assign w  = bus.digit_weights[idx_q];
    assign gt = w > best_q;
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            hid_cnt_q  <= '0;
            feed_cnt_q <= '0;
            out_cnt_q  <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            digit_q    <= '0;
        end else begin
            state_q    <= state_d;
            hid_cnt_q  <= hid_cnt_d;
            feed_cnt_q <= feed_cnt_d;
            out_cnt_q  <= out_cnt_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            digit_q    <= digit_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        hid_cnt_d  = hid_cnt_q;
        feed_cnt_d = feed_cnt_q;
        out_cnt_d  = out_cnt_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        digit_d    = digit_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d   = HID;
                hid_cnt_d = '0;
            end
            HID: if (bus.sig_valid) begin
                hid_cnt_d = hid_cnt_q + 1'b1;
                if (hid_cnt_q == HW'(NUM_HIDDEN-1)) begin
                    state_d    = FEED;
                    out_cnt_d  = '0;
                    feed_cnt_d = '0;
                end
            end
            FEED: if (bus.hidden_ready) begin
                feed_cnt_d = feed_cnt_q + 1'b1;
                if (feed_cnt_q == HW'(NUM_HIDDEN-1)) state_d = OWAIT;
            end
            OWAIT: if (bus.sig_valid) begin
                if (out_cnt_q == OW'(NUM_OUT-1)) begin
                    state_d    = ARGMAX;
                    idx_d      = '0;
                    best_d     = '0;
                    best_idx_d = '0;
                end else begin
                    state_d    = FEED;
                    out_cnt_d  = out_cnt_q + 1'b1;
                    feed_cnt_d = '0;
                end
            end
            ARGMAX: begin
                // strict compare keeps the lowest index on ties
                best_d     = gt ? w : best_q;
                best_idx_d = gt ? idx_q : best_idx_q;
                idx_d      = idx_q + 1'b1;
                if (idx_q == OW'(NUM_OUT-1)) begin
                    state_d = DONE;
                    digit_d = 4'(best_idx_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy_o           = state_q != IDLE;
        done_o           = state_q == DONE;
        layer_sel_o      = state_q == FEED || state_q == OWAIT;
        out_neuron_o     = 4'(out_cnt_q);
        digit_o          = digit_q;
        bus.hidden_valid = state_q == FEED;
        bus.reg_write_en = n_rst && bus.sig_valid && (state_q == HID || state_q == OWAIT);
        bus.reg_address  = state_q == HID   ? 5'(hid_cnt_q) :
                           state_q == FEED  ? 5'(feed_cnt_q) :
                           state_q == OWAIT ? 5'(NUM_HIDDEN) + 5'(out_cnt_q) : '0;
        bus.reg_data_in  = bus.sig_data;
        bus.hidden_data  = bus.reg_data_out;
    end
endmodule

// File: tb/tb_sigmoid_layer_sequencer.sv
// tb_sigmoid_layer_sequencer: directed classification runs against a register-file model.
module tb_sigmoid_layer_sequencer;
    logic       clk = 1'b0;
    logic       n_rst, start, layer_sel, busy, done;
    logic [3:0] out_neuron, digit;
    int         n_checks = 0, n_fail = 0, stall_err = 0, idle_wr = 0;
    logic [4:0] wa[$], xa[$];
    logic [3:0] wd[$], xd[$], xn[$];
    bit         stall_q = 1'b0;
    logic [4:0] stall_a;
    logic [3:0] stall_d;
    logic [3:0] regs [0:31];

    sigmoid_layer_sequencer_if bus ();
    sigmoid_layer_sequencer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start_i     (start),
        .bus         (bus),
        .layer_sel_o (layer_sel),
        .out_neuron_o(out_neuron),
        .busy_o      (busy),
        .done_o      (done),
        .digit_o     (digit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.reg_write_en) regs[bus.reg_address] <= bus.reg_data_in;
    assign bus.reg_data_out = regs[bus.reg_address];
    always_comb for (int k = 0; k < 10; k++) bus.digit_weights[k] = regs[8+k];

    // mid-cycle observer: logs writes and transfers, and checks stalled outputs stay put
    always @(negedge clk) begin
        if (bus.reg_write_en) begin
            wa.push_back(bus.reg_address);
            wd.push_back(bus.reg_data_in);
            if (!busy) idle_wr++;
        end
        if (bus.hidden_valid && bus.hidden_ready) begin
            xa.push_back(bus.reg_address);
            xd.push_back(bus.hidden_data);
            xn.push_back(out_neuron);
        end
        if (bus.hidden_valid && stall_q && (bus.reg_address !== stall_a || bus.hidden_data !== stall_d))
            stall_err++;
        stall_q = bus.hidden_valid && !bus.hidden_ready;
        stall_a = bus.reg_address;
        stall_d = bus.hidden_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [0:7][3:0] hv, input logic [0:9][3:0] ov,
                       input bit stall, input bit noise, input int abort_at, input logic [3:0] exp_digit);
        int ws = wa.size();
        int xs = xd.size();
        int got, cyc, lat;
        bit seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < 8; i++) begin
            if (stall) repeat (3) tick();
            bus.sig_valid = 1'b1;
            bus.sig_data  = hv[i];
            tick();
            bus.sig_valid = 1'b0;
        end
        for (int o = 0; o < 10; o++) begin
            got = 0;
            cyc = 0;
            while (got < 8 && cyc < 100) begin
                bus.hidden_ready = stall ? cyc[0] : 1'b1;
                bus.sig_valid    = noise;
                start            = noise;
                @(negedge clk);
                if (noise) chk({tag, "_feed_wr"}, bus.reg_write_en, 0);
                if (bus.hidden_valid && bus.hidden_ready) got++;
                if (o == abort_at && got == 3) begin
                    chk({tag, "_pre_rst_neuron"}, out_neuron, o);
                    n_rst = 1'b0;
                    tick();
                    n_rst         = 1'b1;
                    bus.sig_valid = 1'b1;
                    @(negedge clk);
                    chk({tag, "_rst_busy"}, busy, 0);
                    chk({tag, "_rst_wr"}, bus.reg_write_en, 0);
                    chk({tag, "_rst_digit"}, digit, 0);
                    chk({tag, "_rst_done"}, done, 0);
                    chk({tag, "_rst_layer"}, layer_sel, 0);
                    bus.sig_valid    = 1'b0;
                    bus.hidden_ready = 1'b1;
                    tick();
                    chk({tag, "_rst_idle"}, busy, 0);
                    return;
                end
                tick();
                cyc++;
            end
            bus.sig_valid    = 1'b0;
            start            = 1'b0;
            bus.hidden_ready = 1'b1;
            chk({tag, "_feed_cnt"}, got, 8);
            if (stall) repeat (3) tick();
            bus.sig_valid = 1'b1;
            bus.sig_data  = ov[o];
            tick();
            bus.sig_valid = 1'b0;
        end
        lat   = 0;
        seen  = 1'b0;
        start = noise;
        while (!seen && lat < 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_done_lat"}, lat, 10);
        chk({tag, "_digit"}, digit, exp_digit);
        tick();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_digit_hold"}, digit, exp_digit);
        chk({tag, "_n_writes"}, wa.size() - ws, 18);
        for (int k = 0; k < 18 && ws + k < wa.size(); k++) begin
            chk({tag, "_waddr"}, wa[ws+k], k);
            chk({tag, "_wdata"}, wd[ws+k], k < 8 ? hv[k] : ov[k-8]);
        end
        chk({tag, "_n_xfers"}, xd.size() - xs, 80);
        for (int k = 0; k < 80 && xs + k < xd.size(); k++) begin
            chk({tag, "_xaddr"}, xa[xs+k], k % 8);
            chk({tag, "_xdata"}, xd[xs+k], hv[k%8]);
            chk({tag, "_xneuron"}, xn[xs+k], k / 8);
        end
    endtask

    initial begin
        logic [0:7][3:0] h_up, h_dn;
        logic [0:9][3:0] o_full, o_tie, o_last, o_zero;
        h_up   = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        h_dn   = {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        o_full = {4'd3, 4'd9, 4'd2, 4'd7, 4'd1, 4'd0, 4'd4, 4'd5, 4'd6, 4'd8};
        o_tie  = {4'd5, 4'd5, 4'd5, 4'd12, 4'd5, 4'd5, 4'd5, 4'd12, 4'd5, 4'd5};
        o_last = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd15};
        o_zero = '0;
        n_rst            = 1'b0;
        start            = 1'b0;
        bus.sig_valid    = 1'b1;
        bus.sig_data     = 4'd6;
        bus.hidden_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_digit", digit, 0);
        chk("reset_layer", layer_sel, 0);
        chk("reset_wr", bus.reg_write_en, 0);
        n_rst = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_sigvalid_wr", bus.reg_write_en, 0);
        tick();
        chk("idle_stays", busy, 0);
        chk("idle_no_log", wa.size(), 0);
        bus.sig_valid = 1'b0;
        run("full",  h_up, o_full, 1'b0, 1'b0, -1, 4'd1);
        run("tie",   h_dn, o_tie,  1'b0, 1'b0, -1, 4'd3);
        run("stall", h_up, o_full, 1'b1, 1'b0, -1, 4'd1);
        run("rstmid", h_up, o_full, 1'b0, 1'b0, 4, 4'd0);
        run("after_rst", h_up, o_full, 1'b0, 1'b0, -1, 4'd1);
        run("noise", h_dn, o_last, 1'b0, 1'b1, -1, 4'd9);
        run("zero",  h_up, o_zero, 1'b1, 1'b0, -1, 4'd0);
        chk("stall_stable", stall_err, 0);
        chk("idle_writes", idle_wr, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
